// File: rtl/pwm_capture_pkg.sv
// Shared constants and helpers for the multi-channel PWM capture block.
package pwm_capture_pkg;

  localparam int CNT_W_DEF = 12;

  // All-ones saturation value for a counter of width w.
  function automatic int unsigned cnt_sat(input int w);
    return (32'd1 << w) - 32'd1;
  endfunction

  function automatic int slice_lo(input int ch, input int w);
    return ch * w;
  endfunction

endpackage

// File: rtl/pwm_capture_ch.sv
// One PWM capture channel: synchroniser, optional glitch filter (PWM_CAPTURE_GLITCH_FILTER_EN),
// edge detect, period/high-time counters and result registers.
module pwm_capture_ch
  import pwm_capture_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int CNT_W       = CNT_W_DEF,
  parameter int FILT_LEN    = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             pwm,
  output logic             level,
  output logic             rise,
  output logic             fall,
  output logic [CNT_W-1:0] high_time,
  output logic [CNT_W-1:0] period,
  output logic             meas_valid,
  output logic             timeout
);

  localparam logic [CNT_W-1:0] SAT = CNT_W'(cnt_sat(CNT_W));

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   raw;
  logic                   s;
  logic                   s_d;
  logic [CNT_W-1:0]       per_cnt;
  logic [CNT_W-1:0]       hi_cnt;
  logic [CNT_W-1:0]       hi_pend;
  logic                   armed;
  logic                   fall_seen;
  logic                   per_sat;
  logic                   hi_sat;

  // FILT_LEN only shapes logic when the filter is built; this keeps it referenced otherwise.
  if (SYNC_STAGES < 2 || FILT_LEN < 2) begin : g_bad_params
  end

  always_ff @(posedge clk) begin
    if (rst) sync_q <= '0;
    else     sync_q <= {sync_q[SYNC_STAGES-2:0], pwm};
  end

  assign raw = sync_q[SYNC_STAGES-1];

`ifdef PWM_CAPTURE_GLITCH_FILTER_EN
  localparam int FW = $clog2(FILT_LEN);

  logic [FW-1:0] filt_cnt;
  logic          filt_s;

  // Accept a new level only after FILT_LEN consecutive samples disagree with the current one.
  always_ff @(posedge clk) begin
    if (rst) begin
      filt_cnt <= '0;
      filt_s   <= 1'b0;
    end else if (raw != filt_s) begin
      if (filt_cnt == FW'(FILT_LEN - 1)) begin
        filt_s   <= raw;
        filt_cnt <= '0;
      end else begin
        filt_cnt <= filt_cnt + 1'b1;
      end
    end else begin
      filt_cnt <= '0;
    end
  end

  assign s = filt_s;
`else
  assign s = raw;
`endif

  always_ff @(posedge clk) begin
    if (rst) s_d <= 1'b0;
    else     s_d <= s;
  end

  assign level   = s;
  assign rise    = s & ~s_d;
  assign fall    = ~s & s_d;
  assign per_sat = (per_cnt == SAT);
  assign hi_sat  = (hi_cnt == SAT);

  // A rise closes the previous period; timeout and fall bookkeeping only apply between rises.
  always_ff @(posedge clk) begin
    if (rst) begin
      per_cnt    <= '0;
      hi_cnt     <= '0;
      hi_pend    <= '0;
      armed      <= 1'b0;
      fall_seen  <= 1'b0;
      high_time  <= '0;
      period     <= '0;
      meas_valid <= 1'b0;
      timeout    <= 1'b0;
    end else begin
      meas_valid <= 1'b0;
      if (rise) begin
        per_cnt <= CNT_W'(1);
        hi_cnt  <= CNT_W'(1);
        if (armed && fall_seen && !per_sat) begin
          period     <= per_cnt;
          high_time  <= hi_pend;
          meas_valid <= 1'b1;
        end
        armed     <= 1'b1;
        fall_seen <= 1'b0;
        timeout   <= 1'b0;
      end else begin
        if (!per_sat)      per_cnt <= per_cnt + 1'b1;
        if (s && !hi_sat)  hi_cnt  <= hi_cnt + 1'b1;
        if (fall) begin
          hi_pend   <= hi_cnt;
          fall_seen <= 1'b1;
        end
        if (per_sat) begin
          timeout <= 1'b1;
          armed   <= 1'b0;
        end
      end
    end
  end

endmodule

// File: rtl/pwm_capture_multi.sv
// Multi-channel PWM input capture; one pwm_capture_ch per channel, results packed per channel.
// Optional glitch filter enabled by defining PWM_CAPTURE_GLITCH_FILTER_EN.
module pwm_capture_multi
  import pwm_capture_pkg::*;
#(
  parameter int N_CH        = 4,
  parameter int SYNC_STAGES = 2,
  parameter int CNT_W       = CNT_W_DEF,
  parameter int FILT_LEN    = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [N_CH-1:0]       i_pwm,
  output logic [N_CH-1:0]       o_pwm_sync,
  output logic [N_CH-1:0]       o_pwm_rise,
  output logic [N_CH-1:0]       o_pwm_fall,
  output logic [N_CH*CNT_W-1:0] o_high_time,
  output logic [N_CH*CNT_W-1:0] o_period,
  output logic [N_CH-1:0]       o_meas_valid,
  output logic [N_CH-1:0]       o_timeout
);

  for (genvar g = 0; g < N_CH; g++) begin : g_ch
    pwm_capture_ch #(
      .SYNC_STAGES(SYNC_STAGES),
      .CNT_W      (CNT_W),
      .FILT_LEN   (FILT_LEN)
    ) u_ch (
      .clk       (clk),
      .rst       (rst),
      .pwm       (i_pwm[g]),
      .level     (o_pwm_sync[g]),
      .rise      (o_pwm_rise[g]),
      .fall      (o_pwm_fall[g]),
      .high_time (o_high_time[slice_lo(g, CNT_W) +: CNT_W]),
      .period    (o_period[slice_lo(g, CNT_W) +: CNT_W]),
      .meas_valid(o_meas_valid[g]),
      .timeout   (o_timeout[g])
    );
  end

endmodule

// File: tb/tb_pwm_capture_multi.sv
// Self-checking bench for pwm_capture_multi: hand vectors, directed corner sequences and
// randomized run-length PWM compared against a timestamp-based reference model.
module tb_pwm_capture_multi;

  localparam int N_CH  = 4;
  localparam int SYNC  = 2;
  localparam int CNT_W = 4;
  localparam int FILT  = 3;
  localparam int M     = (1 << CNT_W) - 1;
  localparam int MAXC  = 4096;

  logic                  clk = 1'b0;
  logic                  rst = 1'b1;
  logic [N_CH-1:0]       i_pwm = '0;
  logic [N_CH-1:0]       o_pwm_sync, o_pwm_rise, o_pwm_fall, o_meas_valid, o_timeout;
  logic [N_CH*CNT_W-1:0] o_high_time, o_period;

  pwm_capture_multi #(
    .N_CH(N_CH), .SYNC_STAGES(SYNC), .CNT_W(CNT_W), .FILT_LEN(FILT)
  ) dut (
    .clk(clk), .rst(rst), .i_pwm(i_pwm),
    .o_pwm_sync(o_pwm_sync), .o_pwm_rise(o_pwm_rise), .o_pwm_fall(o_pwm_fall),
    .o_high_time(o_high_time), .o_period(o_period),
    .o_meas_valid(o_meas_valid), .o_timeout(o_timeout)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int ph    = 0;

  // History of what was applied at each clock edge, and the model's accepted level per edge.
  logic [N_CH-1:0] x_hist   [MAXC];
  bit              rst_hist [MAXC];
  logic [N_CH-1:0] raw_hist [MAXC];
  logic [N_CH-1:0] s_hist   [MAXC];
  logic [N_CH-1:0] sd_hist  [MAXC];

  int ref_c [N_CH];
  bit armed [N_CH];
  bit fs    [N_CH];
  int pend  [N_CH];
  int e_per [N_CH];
  int e_hi  [N_CH];
  bit e_val [N_CH];
  bit e_to  [N_CH];

  typedef struct {
    logic            rst;
    logic [N_CH-1:0] pwm;
    logic [N_CH-1:0] s;
    logic [N_CH-1:0] rise;
    logic [N_CH-1:0] fall;
    logic [N_CH-1:0] valid;
  } vec_t;

  vec_t tbl [12];

  task automatic cmp(input string nm, input int idx, input int got, input int want);
    total++;
    if (got != want) begin
      bad++;
      $display("[TB] FAIL %s idx=%0d cyc=%0d got=%0d want=%0d", nm, idx, cyc, got, want);
    end
  endtask

  // Reference model: levels from delayed input history, measurements from rise/fall timestamps.
  task automatic modelStep(input int k);
    for (int c = 0; c < N_CH; c++) begin
      bit raw_now, s_now, sd_now, pr, pf, flip;
      int el, hi;
      raw_now = 1'b0;
      if (k - SYNC + 1 >= 0) begin
        raw_now = x_hist[k-SYNC+1][c];
        for (int j = k - SYNC + 1; j <= k; j++) if (rst_hist[j]) raw_now = 1'b0;
      end
      raw_hist[k][c] = raw_now;
`ifdef PWM_CAPTURE_GLITCH_FILTER_EN
      if (rst_hist[k] || k == 0) begin
        s_now = 1'b0;
      end else begin
        s_now = s_hist[k-1][c];
        flip  = (k >= FILT);
        for (int j = 1; j <= FILT && flip; j++)
          if (raw_hist[k-j][c] == s_hist[k-1][c]) flip = 1'b0;
        for (int j = k - FILT + 1; j < k && flip; j++)
          if (j >= 0 && rst_hist[j]) flip = 1'b0;
        if (flip) s_now = ~s_now;
      end
`else
      flip  = 1'b0;
      s_now = raw_now | flip;
`endif
      sd_now = (rst_hist[k] || k == 0) ? 1'b0 : s_hist[k-1][c];
      s_hist[k][c]  = s_now;
      sd_hist[k][c] = sd_now;

      if (rst_hist[k] || k == 0) begin
        ref_c[c] = k; armed[c] = 0; fs[c] = 0; pend[c] = 0;
        e_per[c] = 0; e_hi[c] = 0; e_val[c] = 0; e_to[c] = 0;
      end else begin
        pr = s_hist[k-1][c] & ~sd_hist[k-1][c];
        pf = ~s_hist[k-1][c] & sd_hist[k-1][c];
        el = k - 1 - ref_c[c];
        if (el > M) el = M;
        e_val[c] = 1'b0;
        if (pr) begin
          if (armed[c] && fs[c] && el < M) begin
            e_per[c] = el; e_hi[c] = pend[c]; e_val[c] = 1'b1;
          end
          armed[c] = 1'b1; fs[c] = 1'b0; e_to[c] = 1'b0; ref_c[c] = k - 1;
        end else begin
          if (pf) begin
            hi = k - 1 - ref_c[c];
            pend[c] = (hi > M) ? M : hi;
            fs[c] = 1'b1;
          end
          if (el == M) begin
            e_to[c] = 1'b1; armed[c] = 1'b0;
          end
        end
      end
    end
  endtask

  task automatic checkOutput();
    logic [N_CH-1:0] es, er, ef, ev, et;
    for (int c = 0; c < N_CH; c++) begin
      es[c] = s_hist[cyc][c];
      er[c] = s_hist[cyc][c] & ~sd_hist[cyc][c];
      ef[c] = ~s_hist[cyc][c] & sd_hist[cyc][c];
      ev[c] = e_val[c];
      et[c] = e_to[c];
    end
    cmp("sync", 0, int'(o_pwm_sync), int'(es));
    cmp("rise", 0, int'(o_pwm_rise), int'(er));
    cmp("fall", 0, int'(o_pwm_fall), int'(ef));
    cmp("valid", 0, int'(o_meas_valid), int'(ev));
    cmp("timeout", 0, int'(o_timeout), int'(et));
    for (int c = 0; c < N_CH; c++) begin
      cmp("period", c, int'(o_period[c*CNT_W +: CNT_W]), e_per[c]);
      cmp("high_time", c, int'(o_high_time[c*CNT_W +: CNT_W]), e_hi[c]);
    end
  endtask

  task automatic applyStimulus(input logic r, input logic [N_CH-1:0] p);
    if (cyc >= MAXC) begin
      $display("[TB] FAIL cycle_budget cyc=%0d limit=%0d", cyc, MAXC);
      $fatal(1, "[TB] cycle budget exhausted");
    end
    @(negedge clk);
    rst   = r;
    i_pwm = p;
    @(posedge clk);
    x_hist[cyc]   = p;
    rst_hist[cyc] = r;
    modelStep(cyc);
    #1;
    checkOutput();
    cyc++;
  endtask

  function automatic logic [1:0] wave01(input int p);
    return {logic'((p % 2) == 0), logic'((p % 8) < 3)};
  endfunction

  initial begin
    int cnt, cnt2, lat;
    bit found;
    int runl [N_CH];
    logic [N_CH-1:0] lvl;

    tbl[0]  = '{1'b1, 4'b1111, 4'b0000, 4'b0000, 4'b0000, 4'b0000};
    tbl[1]  = '{1'b1, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000};
    tbl[2]  = '{1'b1, 4'b1111, 4'b0000, 4'b0000, 4'b0000, 4'b0000};
    tbl[3]  = '{1'b0, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000};
    tbl[4]  = '{1'b0, 4'b0001, 4'b0000, 4'b0000, 4'b0000, 4'b0000};
    tbl[5]  = '{1'b0, 4'b0001, 4'b0001, 4'b0001, 4'b0000, 4'b0000};
    tbl[6]  = '{1'b0, 4'b0000, 4'b0001, 4'b0000, 4'b0000, 4'b0000};
    tbl[7]  = '{1'b0, 4'b0011, 4'b0000, 4'b0000, 4'b0001, 4'b0000};
    tbl[8]  = '{1'b0, 4'b0010, 4'b0011, 4'b0011, 4'b0000, 4'b0000};
    tbl[9]  = '{1'b0, 4'b0000, 4'b0010, 4'b0000, 4'b0001, 4'b0001};
    tbl[10] = '{1'b0, 4'b0000, 4'b0000, 4'b0000, 4'b0010, 4'b0000};
    tbl[11] = '{1'b0, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000};

    $display("[TB] hand vectors: reset and edge detect");
    for (int i = 0; i < 12; i++) begin
      applyStimulus(tbl[i].rst, tbl[i].pwm);
`ifndef PWM_CAPTURE_GLITCH_FILTER_EN
      cmp("tbl_sync", i, int'(o_pwm_sync), int'(tbl[i].s));
      cmp("tbl_rise", i, int'(o_pwm_rise), int'(tbl[i].rise));
      cmp("tbl_fall", i, int'(o_pwm_fall), int'(tbl[i].fall));
      cmp("tbl_valid", i, int'(o_meas_valid), int'(tbl[i].valid));
`endif
      if (i == 2) cmp("tbl_reset_period0", i, int'(o_period[CNT_W-1:0]), 0);
    end

    $display("[TB] steady waveforms ch0 3/5 and ch1 1/1");
    for (int i = 0; i < 64; i++) begin
      applyStimulus(1'b0, {2'b00, wave01(ph)});
      ph++;
    end
    cmp("steady_ch0_period", 0, int'(o_period[0 +: CNT_W]), 8);
    cmp("steady_ch0_high", 0, int'(o_high_time[0 +: CNT_W]), 3);
`ifndef PWM_CAPTURE_GLITCH_FILTER_EN
    cmp("steady_ch1_period", 1, int'(o_period[CNT_W +: CNT_W]), 2);
    cmp("steady_ch1_high", 1, int'(o_high_time[CNT_W +: CNT_W]), 1);
`endif

    $display("[TB] timeout on ch2");
    for (int i = 0; i < 25; i++) begin
      applyStimulus(1'b0, {2'b01, wave01(ph)});
      ph++;
    end
    cmp("timeout_set", 2, int'(o_timeout[2]), 1);
    cnt = 0;
    for (int i = 0; i < 20; i++) begin
      applyStimulus(1'b0, {1'b0, logic'(((i / 4) % 2) == 1), wave01(ph)});
      ph++;
      if (o_meas_valid[2]) cnt++;
      if (i == 3)  cmp("timeout_held", 2, int'(o_timeout[2]), 1);
      if (i == 10) cmp("timeout_cleared", 2, int'(o_timeout[2]), 0);
    end
    cmp("timeout_strobes", 2, cnt, 1);
    cmp("timeout_ch2_period", 2, int'(o_period[2*CNT_W +: CNT_W]), 8);
    cmp("timeout_ch2_high", 2, int'(o_high_time[2*CNT_W +: CNT_W]), 4);
    cmp("timeout_ch0_period", 0, int'(o_period[0 +: CNT_W]), 8);

    $display("[TB] reset between fall and rise");
    while ((ph % 8) != 5) begin
      applyStimulus(1'b0, {2'b00, wave01(ph)});
      ph++;
    end
    applyStimulus(1'b1, {2'b00, wave01(ph)});
    ph++;
    cnt  = 0;
    cnt2 = 0;
    for (int i = 0; i < 18; i++) begin
      applyStimulus(1'b0, {2'b00, wave01(ph)});
      ph++;
      if (o_meas_valid[0]) begin
        if (i < 10) cnt++;
        else        cnt2++;
      end
    end
    cmp("rst_mid_no_strobe", 0, cnt, 0);
    cmp("rst_mid_next_strobe", 0, cnt2, 1);

    $display("[TB] randomized run-length stimulus");
    lvl = '0;
    for (int c = 0; c < N_CH; c++) runl[c] = 1;
    for (int i = 0; i < 1500; i++) begin
      for (int c = 0; c < N_CH; c++) begin
        runl[c]--;
        if (runl[c] == 0) begin
          lvl[c]  = ~lvl[c];
          runl[c] = ($urandom_range(0, 11) == 0) ? int'($urandom_range(16, 22))
                                                 : int'($urandom_range(1, 6));
        end
      end
      applyStimulus(logic'($urandom_range(0, 299) == 0), lvl);
    end

`ifdef PWM_CAPTURE_GLITCH_FILTER_EN
    $display("[TB] glitch filter on ch3");
    for (int i = 0; i < 3; i++) applyStimulus(1'b1, '0);
    for (int i = 0; i < 6; i++) applyStimulus(1'b0, '0);
    cnt = 0;
    for (int i = 0; i < 12; i++) begin
      applyStimulus(1'b0, (i < 2) ? 4'b1000 : 4'b0000);
      if (o_pwm_rise[3]) cnt++;
    end
    cmp("glitch_no_rise", 3, cnt, 0);
    found = 1'b0;
    lat   = 0;
    for (int i = 0; i < 12; i++) begin
      applyStimulus(1'b0, (i < 3) ? 4'b1000 : 4'b0000);
      if (!found && o_pwm_rise[3]) begin
        found = 1'b1;
        lat   = i + 1;
      end
    end
    cmp("filter_rise_seen", 3, int'(found), 1);
    cmp("filter_latency", 3, lat, SYNC + FILT);
`else
    found = 1'b0;
    lat   = 0;
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pwm_capture_multi.md
Name: pwm_capture_multi

Overview:
- Multi-channel PWM input capture.
- Per channel: synchronises an asynchronous PWM input, flags rising and falling edges, and measures high time and period in clk cycles.
- Reports each completed measurement with a one-cycle valid strobe and flags stalled (constant-level) inputs.
- Sits between the chip input pins and the duty-cycle / decode logic, replacing the single-channel synchroniser with its free-running counter.

Parameters:
- N_CH, 4, number of independent PWM channels (>=1)
- SYNC_STAGES, 2, flip-flops in each input synchroniser (>=2)
- CNT_W, 12, width of the high-time and period counters and results
- FILT_LEN, 3, consecutive equal samples needed to accept a level change (only used with glitch filter, >=2)

Ports:
- clk  input  1  system clock
- rst  input  1  reset, synchronous, active-high
- i_pwm  input  N_CH  asynchronous PWM inputs, one bit per channel
- o_pwm_sync  output  N_CH  synchronised (and filtered, if enabled) level
- o_pwm_rise  output  N_CH  one-cycle pulse on accepted rising edge
- o_pwm_fall  output  N_CH  one-cycle pulse on accepted falling edge
- o_high_time  output  N_CH*CNT_W  last high time; channel k at [k*CNT_W +: CNT_W]
- o_period  output  N_CH*CNT_W  last period, rise to rise; same packing
- o_meas_valid  output  N_CH  one-cycle strobe when a channel's o_high_time/o_period update
- o_timeout  output  N_CH  level; channel has seen no rising edge for 2^CNT_W-1 cycles

Behaviour:
- Reset: one clock and a synchronous, active-high reset, rst. While rst=1 at a clk edge, all synchroniser, filter and counter state clears. All outputs read 0, all channels disarmed.
- Channels are fully independent. Below, s is the channel's accepted level and s_d is s delayed one cycle.
- Synchroniser: o_pwm_sync is i_pwm delayed SYNC_STAGES cycles (no filter).
- Edge detection, combinational from registered state:
  - rise = s & ~s_d
  - fall = ~s & s_d
  - Pulses are coincident with the first cycle of the new o_pwm_sync level.
- Period counter per_cnt:
  - Loads 1 on the rise cycle.
  - Otherwise increments, saturating at 2^CNT_W-1.
- High counter hi_cnt:
  - Loads 1 on the rise cycle.
  - Increments while s=1, saturating.
  - Holds while s=0.
- Fall cycle: latches hi_cnt into a pending high-time register and sets a fall_seen flag.
- Rise cycle, with channel armed, fall_seen=1 and per_cnt not saturated:
  - Next cycle: o_period <= per_cnt, o_high_time <= pending high time, o_meas_valid pulses for 1 cycle.
  - Rise-to-valid latency: 1 cycle.
- Rise cycle otherwise: no update and no strobe.
- Every rise: arms the channel, clears fall_seen, clears o_timeout on the next cycle.
- First rise after reset or after a timeout only arms the channel; the first measurement comes at the second rise.
- Timeout: when per_cnt reaches 2^CNT_W-1:
  - o_timeout <= 1 and the channel disarms.
  - o_high_time/o_period hold their last values.
  - Covers 0% and 100% duty.
- Example: a 3-high/5-low square wave, once measuring, reports period=8, high_time=3.
- Minimum measurable pulse is 1 cycle high or low after synchronisation; shorter input pulses may be lost.
- Reset mid-operation: discards any pending measurement; no strobe is produced.

Optional Feature:
- Macro: PWM_CAPTURE_GLITCH_FILTER_EN.
- Defined:
  - A per-channel filter follows the synchroniser.
  - s changes only after FILT_LEN consecutive synchronised samples differ from s.
  - Added latency is FILT_LEN cycles.
  - Shorter glitches are ignored entirely: no edge pulses, no effect on counters.
- Undefined:
  - No filter logic; s is the synchroniser output.

Decomposition:
- Package pwm_capture_pkg:
  - CNT_W default
  - Counter saturation constant, all ones
  - Packed-result slice helper
- Sub-module pwm_capture_ch:
  - One channel: synchroniser, optional filter, edge detect, counters, result registers.
  - Instantiated N_CH times with a generate loop.
  - Top level only packs buses.

Test Plan:
- Reset: hold rst=1 for 3 cycles with all i_pwm toggling -> all outputs 0; no o_meas_valid within 2 cycles of release.
- Steady waveform: ch0 3-high/5-low -> first strobe at second accepted rise; every strobe reports o_period=8, o_high_time=3; rise/fall pulses exactly 1 cycle, spaced 8 apart.
- Independence: ch1 1-high/1-low alongside ch0 -> ch1 reports period=2, high=1; ch0 results unchanged.
- Timeout: CNT_W=4, hold ch2 high -> o_timeout=1 once per_cnt reaches 15, no strobe. Next two rises -> o_timeout clears after the first; measurement strobes only at the second.
- Reset mid-measurement: rst for 1 cycle between fall and rise -> no strobe at that rise; first valid strobe at the following rise.
- Glitch filter (macro defined, FILT_LEN=3): 2-cycle high glitch on a low input -> no o_pwm_rise; 3-cycle pulse -> o_pwm_rise asserted SYNC_STAGES+3 cycles after the input edge.
